// File: rtl/tlc_pkg.sv
// Shared types for the adaptive traffic light controller: light codes,
// state encoding and the state-to-lights decode.
package tlc_pkg;

    localparam logic [2:0] L_OFF    = 3'b000;
    localparam logic [2:0] L_RED    = 3'b001;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b100;

    typedef enum logic [2:0] {
        HW_G  = 3'd0,
        HW_Y  = 3'd1,
        AR1   = 3'd2,
        LR_G  = 3'd3,
        LR_Y  = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_e;

    typedef struct packed {
        logic [2:0] hw;
        logic [2:0] lr;
    } lights_t;

    // Unlisted codes fall back to all-red, the safe aspect.
    function automatic lights_t light_decode(input state_e s, input logic flash_phase);
        lights_t l;
        l.hw = L_RED;
        l.lr = L_RED;
        case (s)
            HW_G:  l.hw = L_GREEN;
            HW_Y:  l.hw = L_YELLOW;
            LR_G:  l.lr = L_GREEN;
            LR_Y:  l.lr = L_YELLOW;
            FLASH: begin
                if (flash_phase) begin
                    l.hw = L_OFF;
                    l.lr = L_OFF;
                end else begin
                    l.hw = L_YELLOW;
                end
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_dwell_cnt.sv
// Dwell counter: clears on state change, wraps at wrap_at when enabled,
// otherwise saturates at all-ones.
module tlc_dwell_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] wrap_at,
    input  logic             wrap_en,
    output logic [CNT_W-1:0] cyc
);

    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (clr) begin
            cyc_d = '0;
        end else if (wrap_en && (cyc_q == wrap_at)) begin
            cyc_d = '0;
        end else if (cyc_q != '1) begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cyc = cyc_q;

endmodule

// File: rtl/tlc_adaptive_ctrl.sv
// Two-road adaptive traffic light controller with actuated local-road green,
// latched pedestrian request and night flash mode. All outputs are registered.
module tlc_adaptive_ctrl
    import tlc_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int HW_GREEN_MIN = 70,
    parameter int YELLOW       = 25,
    parameter int ALL_RED      = 1,
    parameter int LR_GREEN_MIN = 30,
    parameter int LR_GREEN_MAX = 90,
    parameter int FLASH_HALF   = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lr_has_car,
    input  logic             ped_req,
    input  logic             flash_mode,
    output logic [2:0]       hw_light,
    output logic [2:0]       lr_light,
    output logic             ped_walk,
    output logic [2:0]       st,
    output logic [CNT_W-1:0] cyc
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (HW_GREEN_MIN < 1 || HW_GREEN_MIN > CNT_MAX ||
        YELLOW       < 1 || YELLOW       > CNT_MAX ||
        ALL_RED      < 1 || ALL_RED      > CNT_MAX ||
        LR_GREEN_MIN < 1 || LR_GREEN_MIN > CNT_MAX ||
        LR_GREEN_MAX < LR_GREEN_MIN || LR_GREEN_MAX > CNT_MAX ||
        FLASH_HALF   < 1 || FLASH_HALF   > CNT_MAX) begin : g_param_check
        $error("tlc_adaptive_ctrl: timing parameter out of range for CNT_W");
    end

    // Last cycle index of each timed phase.
    localparam logic [CNT_W-1:0] HGM_LAST  = CNT_W'(HW_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] LGMIN_LAST = CNT_W'(LR_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] LGMAX_LAST = CNT_W'(LR_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] FH_LAST   = CNT_W'(FLASH_HALF - 1);

    state_e           st_q, st_d;
    logic             ped_pending_q, ped_pending_d;
    logic             flash_phase_q, flash_phase_d;
    lights_t          lights_q, lights_d;
    logic             ped_walk_q, ped_walk_d;
    logic [CNT_W-1:0] cyc_w;
    logic             state_chg;

    tlc_dwell_cnt #(
        .CNT_W(CNT_W)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_chg),
        .wrap_at (FH_LAST),
        .wrap_en (st_q == FLASH),
        .cyc     (cyc_w)
    );

    always_comb begin
        st_d = st_q;
        case (st_q)
            HW_G: begin
                if (flash_mode) begin
                    st_d = FLASH;
                end else if (cyc_w >= HGM_LAST && (lr_has_car || ped_pending_q)) begin
                    st_d = HW_Y;
                end
            end
            HW_Y:  if (cyc_w == Y_LAST)  st_d = AR1;
            AR1:   if (cyc_w == AR_LAST) st_d = LR_G;
            LR_G: begin
                if (cyc_w >= LGMIN_LAST && (!lr_has_car || cyc_w == LGMAX_LAST)) begin
                    st_d = LR_Y;
                end
            end
            LR_Y:  if (cyc_w == Y_LAST)  st_d = AR2;
            AR2:   if (cyc_w == AR_LAST) st_d = HW_G;
            FLASH: if (!flash_mode)      st_d = AR2;
            default: st_d = HW_G;
        endcase
    end

    assign state_chg = (st_d != st_q);

    always_comb begin
        ped_pending_d = ped_pending_q;
        if (ped_req && (st_q inside {HW_G, HW_Y, AR1, LR_Y, AR2})) begin
            ped_pending_d = 1'b1;
        end
        // Serving the request (or going dark for the night) drops it, even
        // if the button is pressed on that very cycle.
        if (state_chg && (st_d == LR_G || st_d == FLASH)) begin
            ped_pending_d = 1'b0;
        end

        flash_phase_d = flash_phase_q;
        if (st_d != FLASH) begin
            flash_phase_d = 1'b0;
        end else if (st_q == FLASH && cyc_w == FH_LAST) begin
            flash_phase_d = ~flash_phase_q;
        end

        lights_d   = light_decode(st_d, flash_phase_d);
        ped_walk_d = (st_d == LR_G);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q          <= HW_G;
            ped_pending_q <= 1'b0;
            flash_phase_q <= 1'b0;
            lights_q      <= '{hw: L_GREEN, lr: L_RED};
            ped_walk_q    <= 1'b0;
        end else begin
            st_q          <= st_d;
            ped_pending_q <= ped_pending_d;
            flash_phase_q <= flash_phase_d;
            lights_q      <= lights_d;
            ped_walk_q    <= ped_walk_d;
        end
    end

    assign hw_light = lights_q.hw;
    assign lr_light = lights_q.lr;
    assign ped_walk = ped_walk_q;
    assign st       = st_q;
    assign cyc      = cyc_w;

endmodule

// File: tb/tb_tlc_adaptive_ctrl.sv
// Segment-table bench for tlc_adaptive_ctrl: each record holds inputs for a
// run of cycles and the state/lights/cyc expected to be observed during it.
module tb_tlc_adaptive_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       lr_has_car;
    logic       ped_req;
    logic       flash_mode;
    logic [2:0] hw_light;
    logic [2:0] lr_light;
    logic       ped_walk;
    logic [2:0] st;
    logic [7:0] cyc;

    always #5 clk = ~clk;

    tlc_adaptive_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .lr_has_car (lr_has_car),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .hw_light   (hw_light),
        .lr_light   (lr_light),
        .ped_walk   (ped_walk),
        .st         (st),
        .cyc        (cyc)
    );

    localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001, O = 3'b000;
    localparam logic [2:0] S_HWG = 3'd0, S_HWY = 3'd1, S_AR1 = 3'd2, S_LRG = 3'd3,
                           S_LRY = 3'd4, S_AR2 = 3'd5, S_FL = 3'd6;

    typedef struct {
        logic       car, ped, fl, rs;
        int         len;
        logic [2:0] st;
        int         cyc0;
        logic [2:0] hw, lr;
        logic       walk;
    } vec_t;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] cyc;
        logic [2:0] hw;
        logic [2:0] lr;
        logic       walk;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic [2:0] s, input int len, input int cyc0,
                       input logic car, input logic ped, input logic fl, input logic rs,
                       input logic [2:0] hw, input logic [2:0] lr, input logic walk);
        vec_t v;
        v.st = s; v.len = len; v.cyc0 = cyc0;
        v.car = car; v.ped = ped; v.fl = fl; v.rs = rs;
        v.hw = hw; v.lr = lr; v.walk = walk;
        vecs.push_back(v);
    endtask

    task automatic step(input int seg, input logic car, input logic ped, input logic fl,
                        input logic rs, input exp_t e);
        exp_t got, want;
        lr_has_car = car;
        ped_req    = ped;
        flash_mode = fl;
        rst        = rs;
        sb.push_back(e);
        @(negedge clk);
        got  = {st, cyc, hw_light, lr_light, ped_walk};
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL seg%0d: got st=%0d cyc=%0d hw=%b lr=%b walk=%b, want st=%0d cyc=%0d hw=%b lr=%b walk=%b",
                     seg, got.st, got.cyc, got.hw, got.lr, got.walk,
                     want.st, want.cyc, want.hw, want.lr, want.walk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; lr_has_car = 1'b0; ped_req = 1'b0; flash_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        //   state  len cyc0 car ped fl rst  hw lr walk
        // Car held: max-length lr green.
        add(S_HWG,  70,   0, 1, 0, 0, 0, G, R, 0);
        add(S_HWY,  25,   0, 1, 0, 0, 0, Y, R, 0);
        add(S_AR1,   1,   0, 1, 0, 0, 0, R, R, 0);
        add(S_LRG,  90,   0, 1, 0, 0, 0, R, G, 1);
        add(S_LRY,  25,   0, 1, 0, 0, 0, R, Y, 0);
        add(S_AR2,   1,   0, 0, 0, 0, 0, R, R, 0);
        // No demand: hw green holds, cyc saturates.
        add(S_HWG, 300,   0, 0, 0, 0, 0, G, R, 0);
        add(S_HWG,   1, 255, 0, 0, 0, 1, G, R, 0);
        // Single ped pulse at cyc 10; ped at LR_G entry and during LR_G ignored.
        add(S_HWG,  10,   0, 0, 0, 0, 0, G, R, 0);
        add(S_HWG,   1,  10, 0, 1, 0, 0, G, R, 0);
        add(S_HWG,  59,  11, 0, 0, 0, 0, G, R, 0);
        add(S_HWY,  25,   0, 0, 0, 0, 0, Y, R, 0);
        add(S_AR1,   1,   0, 0, 1, 0, 0, R, R, 0);
        add(S_LRG,   5,   0, 0, 1, 0, 0, R, G, 1);
        add(S_LRG,  25,   5, 0, 0, 0, 0, R, G, 1);
        add(S_LRY,  25,   0, 0, 0, 0, 0, R, Y, 0);
        add(S_AR2,   1,   0, 0, 0, 0, 0, R, R, 0);
        add(S_HWG, 100,   0, 0, 0, 0, 0, G, R, 0);
        // Car drops at LR_G cyc 50.
        add(S_HWG,   1, 100, 1, 0, 0, 0, G, R, 0);
        add(S_HWY,  25,   0, 1, 0, 0, 0, Y, R, 0);
        add(S_AR1,   1,   0, 1, 0, 0, 0, R, R, 0);
        add(S_LRG,  50,   0, 1, 0, 0, 0, R, G, 1);
        add(S_LRG,   1,  50, 0, 0, 0, 0, R, G, 1);
        add(S_LRY,  25,   0, 0, 0, 0, 0, R, Y, 0);
        add(S_AR2,   1,   0, 0, 0, 0, 0, R, R, 0);
        // Flash requested mid HW_Y: sequence completes first.
        add(S_HWG,  70,   0, 1, 0, 0, 0, G, R, 0);
        add(S_HWY,   3,   0, 1, 0, 0, 0, Y, R, 0);
        add(S_HWY,  22,   3, 1, 0, 1, 0, Y, R, 0);
        add(S_AR1,   1,   0, 0, 0, 1, 0, R, R, 0);
        add(S_LRG,  30,   0, 0, 0, 1, 0, R, G, 1);
        add(S_LRY,  25,   0, 0, 0, 1, 0, R, Y, 0);
        add(S_AR2,   1,   0, 0, 0, 1, 0, R, R, 0);
        add(S_HWG,   1,   0, 0, 1, 1, 0, G, R, 0);
        add(S_FL,   50,   0, 0, 0, 1, 0, Y, R, 0);
        add(S_FL,   50,   0, 0, 0, 1, 0, O, O, 0);
        add(S_FL,   50,   0, 0, 0, 1, 0, Y, R, 0);
        add(S_FL,   10,   0, 0, 0, 1, 0, O, O, 0);
        add(S_FL,    1,  10, 0, 0, 0, 0, O, O, 0);
        add(S_AR2,   1,   0, 0, 0, 0, 0, R, R, 0);
        add(S_HWG, 100,   0, 0, 0, 0, 0, G, R, 0);
        // Reset mid LR_Y.
        add(S_HWG,   1, 100, 1, 0, 0, 0, G, R, 0);
        add(S_HWY,  25,   0, 1, 0, 0, 0, Y, R, 0);
        add(S_AR1,   1,   0, 0, 0, 0, 0, R, R, 0);
        add(S_LRG,  30,   0, 0, 0, 0, 0, R, G, 1);
        add(S_LRY,  10,   0, 0, 0, 0, 0, R, Y, 0);
        add(S_LRY,   1,  10, 0, 0, 0, 1, R, Y, 0);
        add(S_HWG,   3,   0, 0, 0, 0, 0, G, R, 0);

        for (int s = 0; s < vecs.size(); s++) begin
            for (int i = 0; i < vecs[s].len; i++) begin
                exp_t e;
                int   c;
                c      = vecs[s].cyc0 + i;
                e.st   = vecs[s].st;
                e.cyc  = (c > 255) ? 8'd255 : 8'(c);
                e.hw   = vecs[s].hw;
                e.lr   = vecs[s].lr;
                e.walk = vecs[s].walk;
                step(s, vecs[s].car, vecs[s].ped, vecs[s].fl, vecs[s].rs, e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
